sprite_renderer: RTL and testbench



---
 rtl/sprite_renderer_pkg.sv | 35 +++
 rtl/sprite_renderer_rom.sv | 27 ++
 rtl/sprite_renderer.sv | 171 +++++++++++++++++
 tb/tb_sprite_renderer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_renderer_pkg.sv
// Shared definitions for the character sprite renderer: default raster
// timing, facing-direction encoding, the animation frame map and the
// built-in sprite image generator used by the sprite ROM.
package sprite_renderer_pkg;

  localparam int H_TOTAL_DEF  = 1328;
  localparam int V_TOTAL_DEF  = 806;
  localparam int V_ACTIVE_DEF = 768;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_UP    = 2'd2,
    DIR_DOWN  = 2'd3
  } dir_e;

  // Animation step to ROM frame: 0,1,2,3 -> 0,1,2,1 (frame 3 is reserved).
  function automatic logic [1:0] anim_frame(input logic [1:0] step);
    return (step == 2'd3) ? 2'd1 : step;
  endfunction

  // Sprite image content for ROM address {frame, row, col}. Each character
  // gets its own image through the seed; a quarter of the pixels are
  // see-through (colour 0) so transparency is exercised on every frame.
  function automatic logic [7:0] rom_image(input logic [7:0] seed,
                                           input logic [9:0] addr);
    logic [7:0] v;
    v = seed + (addr[7:0] * 8'd29) + {addr[9:8], 6'd0};
    if ((addr[5:4] ^ addr[1:0]) == 2'b10) begin
      v = 8'h00;
    end
    return v;
  endfunction

endpackage

// File: rtl/sprite_renderer_rom.sv
// 1024x8 synchronous-read sprite ROM, addressed {frame, row, col}.
// Content is generated at elaboration from the character's image seed.
module sprite_rom
  import sprite_renderer_pkg::*;
#(
  parameter logic [7:0] IMG_SEED = 8'hFC
) (
  input  logic       clk,
  input  logic [9:0] i_addr,
  output logic [7:0] o_data
);

  logic [7:0] w_mem [1024];
  logic [7:0] r_data_p2;

  for (genvar a = 0; a < 1024; a++) begin : g_img
    assign w_mem[a] = rom_image(IMG_SEED, 10'(a));
  end

  // Registered read: data appears one clock after the address.
  always_ff @(posedge clk) begin
    r_data_p2 <= w_mem[i_addr];
  end

  assign o_data = r_data_p2;

endmodule

// File: rtl/sprite_renderer.sv
// Per-pixel enable and colour for one 16x16 animated character sprite.
// The raster position is looked ahead by two pixels so that the two-stage
// pipeline (address/hit register, then ROM read) lines up with the pixel
// currently on h_counter/v_counter. Position, direction and animation state
// change only on the frame-latch cycle, so the sprite never tears.
module sprite_renderer
  import sprite_renderer_pkg::*;
#(
  parameter int         H_TOTAL     = H_TOTAL_DEF,
  parameter int         V_TOTAL     = V_TOTAL_DEF,
  parameter int         V_ACTIVE    = V_ACTIVE_DEF,
  parameter int         ANIM_DIV    = 6,
  parameter logic [7:0] TRANSPARENT = 8'h00,
  parameter logic [7:0] IMG_SEED    = 8'hFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] h_counter,
  input  logic [9:0]  v_counter,
  input  logic [10:0] pos_x,
  input  logic [9:0]  pos_y,
  input  logic [1:0]  dir,
  input  logic        moving,
  output logic        sprite_en,
  output logic [7:0]  sprite_pixel
);

  localparam int FCNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(ANIM_DIV - 1);

  logic              w_frame_evt;
  logic [10:0]       r_lx;
  logic [9:0]        r_ly;
  dir_e              r_ldir;
  logic [FCNT_W-1:0] r_fcnt;
  logic [1:0]        r_step;

  logic [11:0]       w_hx_sum;
  logic              w_hwrap;
  logic [10:0]       w_hx;
  logic [9:0]        w_vy;
  logic [11:0]       w_lx_end;
  logic [10:0]       w_ly_end;
  logic              w_hit;
  logic [3:0]        w_c;
  logic [3:0]        w_r;
  logic [3:0]        w_row;
  logic [3:0]        w_col;
  logic [9:0]        w_addr;

  logic              r_hit_vld_p1;
  logic [9:0]        r_addr_p1;
  logic              r_hit_vld_p2;
  logic [7:0]        w_rom_data_p2;
  logic              w_opaque;

  assign w_frame_evt = (h_counter == 11'd0) && (v_counter == 10'(V_ACTIVE));

  // Frame latch: capture placement and advance the animation once per frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lx   <= 11'h7FF;
      r_ly   <= 10'h3FF;
      r_ldir <= DIR_RIGHT;
      r_fcnt <= '0;
      r_step <= 2'd0;
    end else if (w_frame_evt) begin
      r_lx   <= pos_x;
      r_ly   <= pos_y;
      r_ldir <= dir_e'(dir);
      if (moving) begin
        if (r_fcnt == FCNT_MAX) begin
          r_fcnt <= '0;
          r_step <= r_step + 2'd1;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end
  end

  // Raster position two pixels ahead, wrapping onto the next line/frame.
  always_comb begin
    w_hx_sum = {1'b0, h_counter} + 12'd2;
    w_hwrap  = (w_hx_sum >= 12'(H_TOTAL));
    w_hx     = w_hx_sum[10:0];
    w_vy     = v_counter;
    if (w_hwrap) begin
      w_hx = 11'(w_hx_sum - 12'(H_TOTAL));
      w_vy = (v_counter == 10'(V_TOTAL - 1)) ? 10'd0 : v_counter + 10'd1;
    end
  end

  // Bounds are one bit wider so a sprite at the far edge cannot wrap around.
  assign w_lx_end = {1'b0, r_lx} + 12'd16;
  assign w_ly_end = {1'b0, r_ly} + 11'd16;
  assign w_hit    = (w_hx >= r_lx) && ({1'b0, w_hx} < w_lx_end) &&
                    (w_vy >= r_ly) && ({1'b0, w_vy} < w_ly_end);

  // Only the low nibble of the offset matters inside a 16x16 box.
  assign w_c = w_hx[3:0] - r_lx[3:0];
  assign w_r = w_vy[3:0] - r_ly[3:0];

  // Facing transform from screen offset to source row/column in the ROM.
  always_comb begin
    w_row = w_r;
    w_col = w_c;
    case (r_ldir)
      DIR_RIGHT: begin
        w_row = w_r;
        w_col = w_c;
      end
      DIR_LEFT: begin
        w_row = w_r;
        w_col = 4'd15 - w_c;
      end
      DIR_UP: begin
        w_row = w_c;
        w_col = 4'd15 - w_r;
      end
      DIR_DOWN: begin
        w_row = w_c;
        w_col = w_r;
      end
      default: begin
        w_row = w_r;
        w_col = w_c;
      end
    endcase
  end

  assign w_addr = {anim_frame(r_step), w_row, w_col};

  // Stage 1: hit flag (control, reset) and ROM address (data, free-running).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_vld_p1 <= 1'b0;
    end else begin
      r_hit_vld_p1 <= w_hit;
    end
  end

  // Stage 1 data register for the ROM address.
  always_ff @(posedge clk) begin
    r_addr_p1 <= w_addr;
  end

  // Stage 2: synchronous ROM read; the hit flag is delayed alongside it.
  sprite_rom #(
    .IMG_SEED (IMG_SEED)
  ) u_rom (
    .clk    (clk),
    .i_addr (r_addr_p1),
    .o_data (w_rom_data_p2)
  );

  // Stage 2 hit flag, matched to the ROM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_vld_p2 <= 1'b0;
    end else begin
      r_hit_vld_p2 <= r_hit_vld_p1;
    end
  end

  // Output: stage-2 registers gated so colour is 0 whenever not opaque.
  assign w_opaque     = r_hit_vld_p2 && (w_rom_data_p2 != TRANSPARENT);
  assign sprite_en    = w_opaque;
  assign sprite_pixel = w_opaque ? w_rom_data_p2 : 8'h00;

endmodule

// File: tb/tb_sprite_renderer.sv
// Scoreboard bench for sprite_renderer: a driver issues raster positions and
// pushes the expected pixel for the look-ahead position; a monitor pops and
// compares one entry per clock. Directed probes cover the named scenarios.
module tb_sprite_renderer;

  localparam int H_T   = 1328;
  localparam int V_T   = 806;
  localparam int V_ACT = 768;
  localparam int ADIV  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] h_counter;
  logic [9:0]  v_counter;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic [1:0]  dir;
  logic        moving;
  logic        sprite_en;
  logic [7:0]  sprite_pixel;

  sprite_renderer #(
    .H_TOTAL     (H_T),
    .V_TOTAL     (V_T),
    .V_ACTIVE    (V_ACT),
    .ANIM_DIV    (ADIV),
    .TRANSPARENT (8'h00),
    .IMG_SEED    (8'hFC)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .h_counter    (h_counter),
    .v_counter    (v_counter),
    .pos_x        (pos_x),
    .pos_y        (pos_y),
    .dir          (dir),
    .moving       (moving),
    .sprite_en    (sprite_en),
    .sprite_pixel (sprite_pixel)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    bit en;
    int pix;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference state: what the sprite should currently be showing.
  int m_lx, m_ly, m_dir, m_fcnt, m_step;
  bit garble;
  int ev_x, ev_y, ev_d;
  bit ev_m;

  // Sprite image: seed 0xFC, step 29 per pixel, +64 per frame, and pixels
  // whose (row xor col) low bits equal 2 are see-through.
  function automatic int img(input int f, input int row, input int col);
    int a;
    a = f * 256 + row * 16 + col;
    if (((row ^ col) & 3) == 2) return 0;
    return (252 + (a % 256) * 29 + f * 64) % 256;
  endfunction

  function automatic void model_reset();
    m_lx = 2047; m_ly = 1023; m_dir = 0; m_fcnt = 0; m_step = 0;
  endfunction

  // One raster cycle: drive inputs, push the expected pixel for h+2.
  task automatic cyc(input int h, input int v, input bit rst);
    exp_t e;
    int hx, vy, c, r, sr, sc, val, f;
    @(posedge clk);
    #1;
    reset     = rst;
    h_counter = 11'(h);
    v_counter = 10'(v);
    if (h == 0 && v == V_ACT) begin
      pos_x = 11'(ev_x); pos_y = 10'(ev_y); dir = 2'(ev_d); moving = ev_m;
    end else if (garble) begin
      pos_x  = 11'($urandom_range(0, 2047));
      pos_y  = 10'($urandom_range(0, 1023));
      dir    = 2'($urandom_range(0, 3));
      moving = 1'($urandom_range(0, 1));
    end
    hx = h + 2;
    vy = v;
    if (hx >= H_T) begin
      hx = hx - H_T;
      vy = (v + 1 == V_T) ? 0 : v + 1;
    end
    e.h = hx; e.v = vy; e.en = 1'b0; e.pix = 0;
    if (!rst && hx >= m_lx && hx < m_lx + 16 && vy >= m_ly && vy < m_ly + 16) begin
      c = hx - m_lx;
      r = vy - m_ly;
      case (m_dir)
        0: begin sr = r; sc = c;      end
        1: begin sr = r; sc = 15 - c; end
        2: begin sr = c; sc = 15 - r; end
        default: begin sr = c; sc = r; end
      endcase
      f   = (m_step == 3) ? 1 : m_step;
      val = img(f, sr, sc);
      e.en  = (val != 0);
      e.pix = val;
    end
    if (rst) begin
      for (int i = 1; i < q.size(); i++) begin
        q[i].en = 1'b0;
        q[i].pix = 0;
      end
    end
    q.push_back(e);
    if (rst) begin
      model_reset();
    end else if (h == 0 && v == V_ACT) begin
      m_lx = pos_x; m_ly = pos_y; m_dir = dir;
      if (moving) begin
        m_fcnt = m_fcnt + 1;
        if (m_fcnt == ADIV) begin
          m_fcnt = 0;
          m_step = (m_step + 1) % 4;
        end
      end
    end
  endtask

  task automatic adv(inout int h, inout int v);
    h = h + 1;
    if (h == H_T) begin
      h = 0;
      v = (v + 1 == V_T) ? 0 : v + 1;
    end
  endtask

  task automatic frame_evt(input int px, input int py, input int d, input bit mv);
    ev_x = px; ev_y = py; ev_d = d; ev_m = mv;
    cyc(0, V_ACT, 1'b0);
  endtask

  // Directed comparison of the outputs in the current cycle.
  task automatic chk(input string name, input bit en, input int pix);
    @(negedge clk);
    n_chk++;
    if (sprite_en !== en || sprite_pixel !== 8'(pix)) begin
      n_fail++;
      $display("FAIL %s: got en=%0b pix=%02h, want en=%0b pix=%02h",
               name, sprite_en, sprite_pixel, en, 8'(pix));
    end
  endtask

  // Run the three cycles that end with (x,y) on the counters and check it.
  task automatic probe(input int x, input int y, input string name,
                       input bit en, input int pix);
    int h, v;
    h = x - 2;
    v = y;
    if (h < 0) begin
      h = h + H_T;
      v = (v == 0) ? V_T - 1 : v - 1;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(h, v, 1'b0);
      if (i < 2) adv(h, v);
    end
    chk(name, en, pix);
  endtask

  task automatic probe_img(input int x, input int y, input string name,
                           input int f, input int row, input int col);
    int val;
    val = img(f, row, col);
    probe(x, y, name, val != 0, val);
  endtask

  // Monitor: the output in each cycle answers the position issued 2 cycles ago.
  always @(negedge clk) begin
    if (q.size() == 3) begin
      mon_e = q.pop_front();
      n_chk++;
      if (sprite_en !== mon_e.en || sprite_pixel !== 8'(mon_e.pix)) begin
        n_fail++;
        $display("FAIL scoreboard(h=%0d v=%0d): got en=%0b pix=%02h, want en=%0b pix=%02h",
                 mon_e.h, mon_e.v, sprite_en, sprite_pixel, mon_e.en, 8'(mon_e.pix));
      end
    end
  end

  initial begin
    int seq[8] = '{0, 0, 1, 1, 2, 2, 1, 1};
    reset = 1'b1; h_counter = '0; v_counter = '0;
    pos_x = '0; pos_y = '0; dir = '0; moving = 1'b0;
    garble = 1'b1;
    ev_x = 0; ev_y = 0; ev_d = 0; ev_m = 1'b0;
    model_reset();

    for (int i = 0; i < 4; i++) cyc(10, 10, 1'b1);
    chk("reset_state", 1'b0, 0);
    cyc(11, 10, 1'b0);
    chk("reset_state_after_release", 1'b0, 0);
    probe(100, 50, "no_hit_before_first_frame", 1'b0, 0);

    // Basic placement, facing right, frame 0.
    frame_evt(100, 50, 0, 1'b0);
    probe(100, 50, "basic_topleft", 1'b1, 8'hFC);
    probe(99, 50, "basic_left_of_sprite", 1'b0, 0);
    probe(116, 50, "basic_right_of_sprite", 1'b0, 0);
    probe_img(115, 65, "basic_bottomright", 0, 15, 15);

    // Position changes mid-frame must wait for the frame latch.
    garble = 1'b0;
    pos_x = 11'd200;
    probe(100, 50, "tear_old_pos_held", 1'b1, 8'hFC);
    probe(200, 50, "tear_new_pos_not_yet", 1'b0, 0);
    frame_evt(200, 50, 0, 1'b0);
    probe(200, 50, "tear_new_pos_after_latch", 1'b1, 8'hFC);
    probe(100, 50, "tear_old_pos_gone", 1'b0, 0);
    garble = 1'b1;

    // Line wrap and frame wrap of the look-ahead.
    frame_evt(0, 51, 0, 1'b0);
    probe(0, 51, "line_wrap", 1'b1, 8'hFC);
    frame_evt(0, 0, 0, 1'b0);
    probe(0, 0, "frame_wrap", 1'b1, 8'hFC);

    // Direction transforms.
    frame_evt(300, 100, 1, 1'b0);
    probe_img(300, 100, "dir_left_r0c0", 0, 0, 15);
    probe(315, 100, "dir_left_r0c15", 1'b1, 8'hFC);
    frame_evt(300, 100, 2, 1'b0);
    probe_img(307, 100, "dir_up_r0c7", 0, 7, 15);
    frame_evt(300, 100, 3, 1'b0);
    probe_img(305, 102, "dir_down_r2c5", 0, 5, 2);

    // Animation: 0,0,1,1,2,2,1,1,... with ANIM_DIV=2, holding when idle.
    frame_evt(100, 50, 0, 1'b0);
    probe_img(100, 50, "anim_k0", 0, 0, 0);
    for (int k = 1; k <= 18; k++) begin
      frame_evt(100, 50, 0, 1'b1);
      probe_img(100, 50, $sformatf("anim_k%0d", k), seq[k % 8], 0, 0);
    end
    for (int k = 0; k < 3; k++) begin
      frame_evt(100, 50, 0, 1'b0);
      probe_img(100, 50, $sformatf("anim_hold%0d", k), 1, 0, 0);
    end

    // Reset while the sprite is showing.
    cyc(98, 50, 1'b0);
    cyc(99, 50, 1'b0);
    cyc(100, 50, 1'b1);
    chk("reset_cycle_still_shown", img(1, 0, 0) != 0, img(1, 0, 0));
    cyc(101, 50, 1'b0);
    chk("reset_next_cycle_off", 1'b0, 0);
    probe(100, 50, "reset_no_hit_until_frame", 1'b0, 0);
    frame_evt(100, 50, 0, 1'b0);
    probe(100, 50, "reset_visible_after_frame", 1'b1, 8'hFC);

    // Randomised placements, including right/bottom edges.
    for (int fr = 0; fr < 40; fr++) begin
      int px, py, h, v;
      px = (fr % 5 == 0) ? $urandom_range(H_T - 16, H_T - 1) : $urandom_range(0, H_T - 1);
      py = (fr % 7 == 0) ? $urandom_range(V_T - 16, V_T - 1) : $urandom_range(0, V_T - 1);
      frame_evt(px, py, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      for (int ln = -1; ln < 17; ln++) begin
        h = px - 3;
        v = (py + ln + V_T) % V_T;
        if (h < 0) begin
          h = h + H_T;
          v = (v + V_T - 1) % V_T;
        end
        for (int i = 0; i < 22; i++) begin
          cyc(h, v, 1'b0);
          adv(h, v);
        end
      end
    end

    cyc(5, 5, 1'b0);
    cyc(6, 5, 1'b0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
